// File: rtl/bcd_disp_pkg.sv
// Shared glyphs, limit-mode encoding and single-digit BCD arithmetic
// for the BCD up/down display counter.
package bcd_disp_pkg;

    // Segment order {g,f,e,d,c,b,a}, active-low
    localparam logic [6:0] GLYPH_0     = 7'b1000000;
    localparam logic [6:0] GLYPH_1     = 7'b1111001;
    localparam logic [6:0] GLYPH_2     = 7'b0100100;
    localparam logic [6:0] GLYPH_3     = 7'b0110000;
    localparam logic [6:0] GLYPH_4     = 7'b0011001;
    localparam logic [6:0] GLYPH_5     = 7'b0010010;
    localparam logic [6:0] GLYPH_6     = 7'b0000010;
    localparam logic [6:0] GLYPH_7     = 7'b1111000;
    localparam logic [6:0] GLYPH_8     = 7'b0000000;
    localparam logic [6:0] GLYPH_9     = 7'b0010000;
    localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

    typedef enum logic {
        LIMIT_SAT  = 1'b0,
        LIMIT_WRAP = 1'b1
    } limit_mode_e;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = GLYPH_0;
            4'd1:    s = GLYPH_1;
            4'd2:    s = GLYPH_2;
            4'd3:    s = GLYPH_3;
            4'd4:    s = GLYPH_4;
            4'd5:    s = GLYPH_5;
            4'd6:    s = GLYPH_6;
            4'd7:    s = GLYPH_7;
            4'd8:    s = GLYPH_8;
            4'd9:    s = GLYPH_9;
            default: s = GLYPH_BLANK;
        endcase
        return s;
    endfunction

    // Returns {carry_out, digit}
    function automatic logic [4:0] bcd_inc(input logic [3:0] d,
                                           input logic ci);
        if (!ci)
            return {1'b0, d};
        if (d >= 4'd9)
            return {1'b1, 4'd0};
        return {1'b0, d + 4'd1};
    endfunction

    // Returns {borrow_out, digit}
    function automatic logic [4:0] bcd_dec(input logic [3:0] d,
                                           input logic bi);
        if (!bi)
            return {1'b0, d};
        if (d == 4'd0)
            return {1'b1, 4'd9};
        if (d > 4'd9)
            return {1'b0, 4'd9};
        return {1'b0, d - 4'd1};
    endfunction

endpackage

// File: rtl/bcd_updown_display_btn.sv
// Push-button conditioner: 2-flop sync, debounce and rising-edge step.
// Hold-to-repeat is built only when AUTO_REPEAT_EN is defined.
module btn_conditioner
    import bcd_disp_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int HOLD_CYCLES     = 50000000,
    parameter int REPEAT_CYCLES   = 10000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    input  logic other_i,
    output logic level_o,
    output logic step_o
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES);

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q;
    logic          level_d1_q;
    logic [DW-1:0] db_cnt_q;
    logic          edge_w;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            level_q    <= 1'b0;
            level_d1_q <= 1'b0;
            db_cnt_q   <= '0;
        end else begin
            sync1_q    <= btn_i;
            sync2_q    <= sync1_q;
            level_d1_q <= level_q;
            // Any sample agreeing with the current level restarts the count
            if (sync2_q == level_q) begin
                db_cnt_q <= '0;
            end else if (db_cnt_q == DW'(DEBOUNCE_CYCLES - 1)) begin
                level_q  <= sync2_q;
                db_cnt_q <= '0;
            end else begin
                db_cnt_q <= db_cnt_q + 1'b1;
            end
        end
    end

    assign edge_w  = level_q & ~level_d1_q;
    assign level_o = level_q;

`ifdef AUTO_REPEAT_EN
    localparam int RMAX = (HOLD_CYCLES > REPEAT_CYCLES) ?
                          HOLD_CYCLES : REPEAT_CYCLES;
    localparam int RW   = $clog2(RMAX + 1);

    logic [RW-1:0] rpt_cnt_q;
    logic          rpt_armed_q;
    logic          held_w;
    logic          fire_w;

    assign held_w = level_q & ~other_i;
    assign fire_w = held_w &
                    (rpt_cnt_q == (rpt_armed_q ? RW'(REPEAT_CYCLES)
                                               : RW'(HOLD_CYCLES)));

    // Counter is 0 on the edge cycle, so the first repeat lands HOLD later
    always_ff @(posedge clk) begin
        if (rst || !held_w) begin
            rpt_cnt_q   <= '0;
            rpt_armed_q <= 1'b0;
        end else if (fire_w) begin
            rpt_cnt_q   <= RW'(1);
            rpt_armed_q <= 1'b1;
        end else begin
            rpt_cnt_q   <= rpt_cnt_q + 1'b1;
        end
    end

    assign step_o = edge_w | fire_w;
`else
    logic unused_rpt;
    assign unused_rpt = other_i ^ (HOLD_CYCLES != REPEAT_CYCLES);
    assign step_o     = edge_w;
`endif

endmodule

// File: rtl/bcd_updown_display.sv
// Multi-digit BCD up/down counter with multiplexed 7-seg scan.
// Define AUTO_REPEAT_EN to enable hold-to-repeat on the buttons.
module bcd_updown_display
    import bcd_disp_pkg::*;
#(
    parameter int DIGITS          = 4,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int REFRESH_CYCLES  = 5000,
    parameter int WRAP            = 0,
    parameter int HOLD_CYCLES     = 50000000,
    parameter int REPEAT_CYCLES   = 10000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  btn_plus,
    input  logic                  btn_minus,
    output logic [4*DIGITS-1:0]   value,
    output logic                  at_max,
    output logic                  at_min,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     an
);

    localparam limit_mode_e MODE = (WRAP != 0) ? LIMIT_WRAP : LIMIT_SAT;
    localparam int RFW = $clog2(REFRESH_CYCLES);
    localparam int IW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic lvl_plus, lvl_minus;
    logic step_plus, step_minus;

    btn_conditioner #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .HOLD_CYCLES     (HOLD_CYCLES),
        .REPEAT_CYCLES   (REPEAT_CYCLES)
    ) u_plus (
        .clk     (clk),
        .rst     (rst),
        .btn_i   (btn_plus),
        .other_i (lvl_minus),
        .level_o (lvl_plus),
        .step_o  (step_plus)
    );

    btn_conditioner #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .HOLD_CYCLES     (HOLD_CYCLES),
        .REPEAT_CYCLES   (REPEAT_CYCLES)
    ) u_minus (
        .clk     (clk),
        .rst     (rst),
        .btn_i   (btn_minus),
        .other_i (lvl_plus),
        .level_o (lvl_minus),
        .step_o  (step_minus)
    );

    logic [4*DIGITS-1:0] value_q, value_d;
    logic [4*DIGITS-1:0] inc_val, dec_val;
    logic                inc_co, dec_bo;

    always_comb begin
        logic       c;
        logic       b;
        logic [4:0] r;
        c       = 1'b1;
        b       = 1'b1;
        r       = '0;
        inc_val = '0;
        dec_val = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r                = bcd_inc(value_q[4*i +: 4], c);
            inc_val[4*i +: 4] = r[3:0];
            c                = r[4];
            r                = bcd_dec(value_q[4*i +: 4], b);
            dec_val[4*i +: 4] = r[3:0];
            b                = r[4];
        end
        inc_co = c;
        dec_bo = b;
    end

    // A final carry/borrow means the counter sat on a limit
    always_comb begin
        value_d = value_q;
        if (step_plus && !step_minus) begin
            if (!inc_co || MODE == LIMIT_WRAP)
                value_d = inc_val;
        end else if (step_minus && !step_plus) begin
            if (!dec_bo || MODE == LIMIT_WRAP)
                value_d = dec_val;
        end
    end

    logic [RFW-1:0]    refresh_q;
    logic [IW-1:0]     idx_q;
    logic [DIGITS-1:0] an_q;
    logic [6:0]        seg_q;
    logic [3:0]        sel_digit;

    assign sel_digit = value_q[{idx_q, 2'b00} +: 4];

    always_ff @(posedge clk) begin
        if (rst) begin
            value_q   <= '0;
            refresh_q <= '0;
            idx_q     <= '0;
            an_q      <= '1;
            seg_q     <= GLYPH_BLANK;
        end else begin
            value_q <= value_d;
            if (refresh_q == RFW'(REFRESH_CYCLES - 1)) begin
                refresh_q <= '0;
                idx_q     <= (idx_q == IW'(DIGITS - 1)) ? '0
                                                        : idx_q + 1'b1;
            end else begin
                refresh_q <= refresh_q + 1'b1;
            end
            an_q  <= ~(DIGITS'(1) << idx_q);
            seg_q <= bcd_to_seg(sel_digit);
        end
    end

    assign value  = value_q;
    assign at_max = (value_q == {DIGITS{4'h9}});
    assign at_min = (value_q == '0);
    assign seg    = seg_q;
    assign an     = an_q;

endmodule

// File: tb/tb_bcd_updown_display.sv
// Scoreboard bench for bcd_updown_display: saturating and wrapping
// instances, value changes checked against a queue of expected values.
module tb_bcd_updown_display;

    localparam int D   = 2;
    localparam int DEB = 4;
    localparam int REF = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic bp0 = 1'b0, bm0 = 1'b0, bp1 = 1'b0, bm1 = 1'b0;

    logic [7:0] val0, val1;
    logic       mx0, mn0, mx1, mn1;
    logic [6:0] seg0, seg1;
    logic [1:0] an0, an1;

    always #5 clk = ~clk;

    bcd_updown_display #(
        .DIGITS(D), .DEBOUNCE_CYCLES(DEB), .REFRESH_CYCLES(REF), .WRAP(0),
        .HOLD_CYCLES(50), .REPEAT_CYCLES(20)
    ) dut (
        .clk(clk), .rst(rst), .btn_plus(bp0), .btn_minus(bm0),
        .value(val0), .at_max(mx0), .at_min(mn0), .seg(seg0), .an(an0)
    );

    bcd_updown_display #(
        .DIGITS(D), .DEBOUNCE_CYCLES(DEB), .REFRESH_CYCLES(REF), .WRAP(1),
        .HOLD_CYCLES(50), .REPEAT_CYCLES(20)
    ) dut_w (
        .clk(clk), .rst(rst), .btn_plus(bp1), .btn_minus(bm1),
        .value(val1), .at_max(mx1), .at_min(mn1), .seg(seg1), .an(an1)
    );

    typedef struct {
        logic [7:0] v;
        int         cyc;
    } exp_t;

    exp_t       q0[$];
    exp_t       q1[$];
    exp_t       e0, e1;
    int         cyc = 0;
    int         n_chk = 0;
    int         n_pass = 0;
    bit         mon_en = 1'b0;
    logic [7:0] prev0, prev1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h", name, act, exp);
    endtask

    function automatic logic [7:0] bcd8(input int n);
        return 8'(((n / 10) << 4) | (n % 10));
    endfunction

    function automatic exp_t mk(input int n, input int c);
        exp_t e;
        e.v   = bcd8(n);
        e.cyc = c;
        return e;
    endfunction

    // Monitor: every change of value consumes one expected entry
    always @(negedge clk) begin
        if (mon_en && val0 !== prev0) begin
            if (q0.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected0: got %0h required %0h", val0, prev0);
            end else begin
                e0 = q0.pop_front();
                check("value0", {24'd0, val0}, {24'd0, e0.v});
                if (e0.cyc >= 0) check("latency0", cyc, e0.cyc);
            end
        end
        if (mon_en && val1 !== prev1) begin
            if (q1.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected1: got %0h required %0h", val1, prev1);
            end else begin
                e1 = q1.pop_front();
                check("value1", {24'd0, val1}, {24'd0, e1.v});
                if (e1.cyc >= 0) check("latency1", cyc, e1.cyc);
            end
        end
        prev0 = val0;
        prev1 = val1;
    end

    task automatic set_btn(input int which, input logic v);
        case (which)
            0: bp0 = v;
            1: bm0 = v;
            2: bp1 = v;
            3: bm1 = v;
            4: begin bp0 = v; bm0 = v; end
            default: ;
        endcase
    endtask

    task automatic press(input int which);
        @(negedge clk);
        set_btn(which, 1'b1);
        repeat (12) @(negedge clk);
        set_btn(which, 1'b0);
        repeat (10) @(negedge clk);
    endtask

    task automatic drain(input string name);
        int k = 0;
        while ((q0.size() != 0 || q1.size() != 0) && k < 60) begin
            @(negedge clk);
            k++;
        end
        n_chk++;
        if (q0.size() == 0 && q1.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL drain %s: pending %0d/%0d required 0",
                     name, q0.size(), q1.size());
            q0.delete();
            q1.delete();
        end
    endtask

    task automatic scan_check();
        int         run = 0;
        bit         first = 1'b1;
        logic [1:0] last;
        @(negedge clk);
        last = an0;
        for (int s = 0; s < 16; s++) begin
            @(negedge clk);
            check("scan_seg", {23'd0, an0, seg0},
                  an0[0] ? {23'd0, 2'b01, 7'b0011001}
                         : {23'd0, 2'b10, 7'b0100100});
            if (an0 == last) begin
                run++;
            end else begin
                if (!first) check("scan_run", run, 3);
                first = 1'b0;
                last  = an0;
                run   = 1;
            end
        end
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        check("rst_value", {24'd0, val0}, 32'h0);
        check("rst_an", {30'd0, an0}, 32'h3);
        check("rst_seg", {25'd0, seg0}, 32'h7f);
        check("rst_min", {31'd0, mn0}, 32'h1);
        check("rst_max", {31'd0, mx0}, 32'h0);
        rst    = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        check("an_first", {30'd0, an0}, 32'h2);

        // Bounce: toggle each cycle, finishing high
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bp0 = i[0];
            if (i == 9) q0.push_back(mk(1, cyc + 7));
        end
        repeat (20) @(negedge clk);
        bp0 = 1'b0;
        repeat (10) @(negedge clk);
        drain("bounce");

        // Count up to 99, pausing at 42 to observe the scan
        for (int i = 2; i <= 99; i++) begin
            q0.push_back(mk(i, -1));
            press(0);
            if (i == 42) begin
                drain("to42");
                scan_check();
            end
        end
        drain("to99");
        check("val99", {24'd0, val0}, 32'h99);
        check("max99", {31'd0, mx0}, 32'h1);
        check("min99", {31'd0, mn0}, 32'h0);

        press(0);
        drain("sat");
        check("sat_val", {24'd0, val0}, 32'h99);
        check("sat_max", {31'd0, mx0}, 32'h1);

        q0.push_back(mk(98, -1));
        press(1);
        drain("dec");
        check("dec_max", {31'd0, mx0}, 32'h0);

        press(4);
        drain("simul");
        check("simul_val", {24'd0, val0}, 32'h98);

        // Wrapping instance
        check("w_min0", {31'd0, mn1}, 32'h1);
        q1.push_back(mk(99, -1));
        press(3);
        drain("wrap_dn");
        check("w_max", {31'd0, mx1}, 32'h1);
        q1.push_back(mk(0, -1));
        press(2);
        drain("wrap_up");
        check("w_val0", {24'd0, val1}, 32'h0);
        check("w_min", {31'd0, mn1}, 32'h1);

        for (int i = 1; i <= 37; i++) begin
            q1.push_back(mk(i, -1));
            press(2);
        end
        drain("to37");
        check("w_val37", {24'd0, val1}, 32'h37);

        // Reset two cycles into a debounce, button held across release
        @(negedge clk);
        bp1 = 1'b1;
        repeat (2) @(negedge clk);
        q0.push_back(mk(0, -1));
        q1.push_back(mk(0, -1));
        rst = 1'b1;
        @(negedge clk);
        check("mrst_val", {24'd0, val1}, 32'h0);
        check("mrst_seg", {25'd0, seg1}, 32'h7f);
        check("mrst_an", {30'd0, an1}, 32'h3);
        @(negedge clk);
        rst = 1'b0;
        n = cyc;
        q1.push_back(mk(1, n + 7));
        repeat (4) @(negedge clk);
        check("mrst_hold", {24'd0, val1}, 32'h0);
        repeat (10) @(negedge clk);
        bp1 = 1'b0;
        repeat (10) @(negedge clk);
        drain("mrst");
        check("mrst_step", {24'd0, val1}, 32'h01);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
